// File: rtl/ccx_arb_srcq_n.sv
// CCX arbiter source-queue tracker: DEPTH entries, occupancy count, atomics.
// Optional sticky protocol error flop under CCX_ARB_SRCQ_ERR_EN.
module ccx_arb_srcq_n #(
  parameter int DEPTH = 2,
  parameter int CNT_W = 2
) (
  input  logic             rclk,
  input  logic             reset_d1,
  input  logic             req_q,
  input  logic             atom_q,
  input  logic             grant_a,
  output logic             qfull,
  output logic [DEPTH-1:0] wsel,
  output logic             shift_x,
  output logic             q0_hold_a,
  output logic             atom_a,
  output logic [CNT_W-1:0] qcnt,
  output logic             atom_pend,
  output logic             err
);

  logic             req_a;
  logic             qfull_a;
  logic             incr_a;
  logic             decr_a;
  logic             shift_a;
  logic             atom_pend_next;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic [CNT_W-1:0] widx;

  // Reset masks the a-stage strobes so nothing moves while held.
  always_comb begin
    incr_a = (req_a | atom_pend) & ~qfull_a & ~reset_d1;
    decr_a = grant_a & (cnt != '0) & ~reset_d1;
  end

  always_comb begin
    cnt_next = cnt + CNT_W'(incr_a) - CNT_W'(decr_a);
    qfull    = (cnt_next == CNT_W'(DEPTH));
    shift_a  = grant_a & (cnt >= CNT_W'(2));
  end

  // A grant in the same cycle shifts the tail down, so write one lower.
  always_comb begin
    widx = cnt - CNT_W'(decr_a);
    wsel = '0;
    for (int i = 0; i < DEPTH; i++) begin
      wsel[i] = incr_a && (widx == CNT_W'(i));
    end
  end

  always_comb begin
    atom_pend_next = (req_a & atom_a & incr_a)
                   | (atom_pend & ~incr_a);
  end

  always_ff @(posedge rclk or posedge reset_d1) begin
    if (reset_d1) begin
      req_a     <= 1'b0;
      atom_a    <= 1'b0;
      qfull_a   <= 1'b0;
      cnt       <= '0;
      atom_pend <= 1'b0;
      shift_x   <= 1'b0;
    end else begin
      req_a     <= req_q;
      atom_a    <= atom_q;
      qfull_a   <= qfull;
      cnt       <= cnt_next;
      atom_pend <= atom_pend_next;
      shift_x   <= shift_a;
    end
  end

  assign q0_hold_a = wsel[0] | shift_x;
  assign qcnt      = cnt;

`ifdef CCX_ARB_SRCQ_ERR_EN
  logic err_set;

  always_comb begin
    err_set = (req_a & qfull_a)
            | (req_a & atom_pend)
            | (grant_a & (cnt == '0));
  end

  always_ff @(posedge rclk or posedge reset_d1) begin
    if (reset_d1) begin
      err <= 1'b0;
    end else if (err_set) begin
      err <= 1'b1;
    end
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_ccx_arb_srcq_n.sv
// Directed bench for ccx_arb_srcq_n: DEPTH=4 vector table plus
// hand sequences on a DEPTH=2 instance and an async reset check.
module tb_ccx_arb_srcq_n;

`ifdef CCX_ARB_SRCQ_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;

  logic       req4 = 1'b0;
  logic       atom4 = 1'b0;
  logic       gnt4 = 1'b0;
  logic       qfull4;
  logic [3:0] wsel4;
  logic       shx4;
  logic       hold4;
  logic       atma4;
  logic [2:0] qcnt4;
  logic       pend4;
  logic       err4;

  logic       req2 = 1'b0;
  logic       atom2 = 1'b0;
  logic       gnt2 = 1'b0;
  logic       qfull2;
  logic [1:0] wsel2;
  logic       shx2;
  logic       hold2;
  logic       atma2;
  logic [1:0] qcnt2;
  logic       pend2;
  logic       err2;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  ccx_arb_srcq_n #(.DEPTH(4), .CNT_W(3)) u4 (
    .rclk      (clk),
    .reset_d1  (rst),
    .req_q     (req4),
    .atom_q    (atom4),
    .grant_a   (gnt4),
    .qfull     (qfull4),
    .wsel      (wsel4),
    .shift_x   (shx4),
    .q0_hold_a (hold4),
    .atom_a    (atma4),
    .qcnt      (qcnt4),
    .atom_pend (pend4),
    .err       (err4)
  );

  ccx_arb_srcq_n #(.DEPTH(2), .CNT_W(2)) u2 (
    .rclk      (clk),
    .reset_d1  (rst),
    .req_q     (req2),
    .atom_q    (atom2),
    .grant_a   (gnt2),
    .qfull     (qfull2),
    .wsel      (wsel2),
    .shift_x   (shx2),
    .q0_hold_a (hold2),
    .atom_a    (atma2),
    .qcnt      (qcnt2),
    .atom_pend (pend2),
    .err       (err2)
  );

  typedef struct {
    logic       req;
    logic       atom;
    logic       grant;
    logic [3:0] wsel;
    logic [2:0] qcnt;
    logic       qfull;
    logic       shx;
    logic       hold;
    logic       atma;
    logic       pend;
    logic       err;
  } vec_t;

  vec_t tv[17];

  function automatic vec_t mk(
    int r, int a, int g, int w, int q,
    int f, int s, int h, int at, int p, int e
  );
    vec_t v;
    v.req   = r[0];
    v.atom  = a[0];
    v.grant = g[0];
    v.wsel  = w[3:0];
    v.qcnt  = q[2:0];
    v.qfull = f[0];
    v.shx   = s[0];
    v.hold  = h[0];
    v.atma  = at[0];
    v.pend  = p[0];
    v.err   = e[0] & ERR_EN;
    return v;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic chk4_zero(string tag);
    chk({tag, ".wsel"},  32'(wsel4),  0);
    chk({tag, ".qcnt"},  32'(qcnt4),  0);
    chk({tag, ".qfull"}, 32'(qfull4), 0);
    chk({tag, ".shx"},   32'(shx4),   0);
    chk({tag, ".hold"},  32'(hold4),  0);
    chk({tag, ".atma"},  32'(atma4),  0);
    chk({tag, ".pend"},  32'(pend4),  0);
    chk({tag, ".err"},   32'(err4),   0);
  endtask

  initial begin
    //            r a g wsel    q f s h at p e
    tv[0]  = mk(1,0,0,'b0000,0,0,0,0,0,0,0);
    tv[1]  = mk(1,0,0,'b0001,0,0,0,1,0,0,0);
    tv[2]  = mk(1,0,0,'b0010,1,0,0,0,0,0,0);
    tv[3]  = mk(1,0,0,'b0100,2,0,0,0,0,0,0);
    tv[4]  = mk(0,0,1,'b0100,3,0,0,0,0,0,0);
    tv[5]  = mk(1,1,0,'b0000,3,0,1,1,0,0,0);
    tv[6]  = mk(0,0,0,'b1000,3,1,0,0,1,0,0);
    tv[7]  = mk(0,0,0,'b0000,4,1,0,0,0,1,0);
    tv[8]  = mk(0,0,1,'b0000,4,0,0,0,0,1,0);
    tv[9]  = mk(1,0,0,'b1000,3,1,1,1,0,1,0);
    tv[10] = mk(0,0,1,'b0000,4,0,0,0,0,0,0);
    tv[11] = mk(0,0,0,'b0000,3,0,1,1,0,0,1);
    tv[12] = mk(0,0,1,'b0000,3,0,0,0,0,0,1);
    tv[13] = mk(0,0,1,'b0000,2,0,1,1,0,0,1);
    tv[14] = mk(0,0,1,'b0000,1,0,1,1,0,0,1);
    tv[15] = mk(0,0,1,'b0000,0,0,0,0,0,0,1);
    tv[16] = mk(0,0,0,'b0000,0,0,0,0,0,0,1);

    // Reset state
    repeat (2) @(negedge clk);
    chk4_zero("rst4");
    chk("rst2.qcnt", 32'(qcnt2), 0);
    chk("rst2.wsel", 32'(wsel2), 0);
    rst = 1'b0;

    // DEPTH=4 table: fill, grant+write, atomic at DEPTH-1,
    // full blocking, drain, empty grant
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      req4  = tv[i].req;
      atom4 = tv[i].atom;
      gnt4  = tv[i].grant;
      #1;
      chk($sformatf("v%0d.wsel", i),  32'(wsel4),  32'(tv[i].wsel));
      chk($sformatf("v%0d.qcnt", i),  32'(qcnt4),  32'(tv[i].qcnt));
      chk($sformatf("v%0d.qfull", i), 32'(qfull4), 32'(tv[i].qfull));
      chk($sformatf("v%0d.shx", i),   32'(shx4),   32'(tv[i].shx));
      chk($sformatf("v%0d.hold", i),  32'(hold4),  32'(tv[i].hold));
      chk($sformatf("v%0d.atma", i),  32'(atma4),  32'(tv[i].atma));
      chk($sformatf("v%0d.pend", i),  32'(pend4),  32'(tv[i].pend));
      chk($sformatf("v%0d.err", i),   32'(err4),   32'(tv[i].err));
    end

    // DEPTH=2 back-to-back fill
    @(negedge clk);
    req2 = 1'b1;
    @(negedge clk);
    req2 = 1'b1;
    #1;
    chk("f2a.wsel",  32'(wsel2),  'b01);
    chk("f2a.qcnt",  32'(qcnt2),  0);
    chk("f2a.qfull", 32'(qfull2), 0);
    chk("f2a.hold",  32'(hold2),  1);
    @(negedge clk);
    req2 = 1'b0;
    #1;
    chk("f2b.wsel",  32'(wsel2),  'b10);
    chk("f2b.qcnt",  32'(qcnt2),  1);
    chk("f2b.qfull", 32'(qfull2), 1);
    @(negedge clk);
    #1;
    chk("f2c.wsel",  32'(wsel2),  0);
    chk("f2c.qcnt",  32'(qcnt2),  2);
    chk("f2c.qfull", 32'(qfull2), 1);

    // Build qcnt=3 with atom_pend=1 on DEPTH=4, then async reset
    @(negedge clk);
    req4 = 1'b1;
    @(negedge clk);
    req4 = 1'b1;
    @(negedge clk);
    req4 = 1'b1;
    atom4 = 1'b1;
    @(negedge clk);
    req4 = 1'b0;
    atom4 = 1'b0;
    @(negedge clk);
    #1;
    chk("pre.qcnt", 32'(qcnt4), 3);
    chk("pre.pend", 32'(pend4), 1);
    chk("pre.wsel", 32'(wsel4), 'b1000);
    rst = 1'b1;
    #1;
    chk4_zero("arst4");
    chk("arst2.qcnt",  32'(qcnt2),  0);
    chk("arst2.qfull", 32'(qfull2), 0);

    @(negedge clk);
    rst = 1'b0;
    req4 = 1'b1;
    @(negedge clk);
    req4 = 1'b0;
    #1;
    chk("post.wsel", 32'(wsel4), 'b0001);
    chk("post.qcnt", 32'(qcnt4), 0);

    // Empty grant on fresh DEPTH=2 instance
    @(negedge clk);
    gnt2 = 1'b1;
    #1;
    chk("eg.qcnt", 32'(qcnt2), 0);
    chk("eg.shx",  32'(shx2),  0);
    chk("eg.err0", 32'(err2),  0);
    @(negedge clk);
    gnt2 = 1'b0;
    #1;
    chk("eg.qcnt1", 32'(qcnt2), 0);
    chk("eg.shx1",  32'(shx2),  0);
    chk("eg.err1",  32'(err2),  32'(ERR_EN));
    chk("eg.u4err", 32'(err4),  0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ccx_arb_srcq_n.md
Name: ccx_arb_srcq_n

Overview:
- Parametrised successor to the 2-entry CCX arbiter source-queue tracker. Supports a configurable queue depth and an occupancy count output.
- Generates one-hot write selects and a shift strobe for the arbiter datapath queue (entry 0 = head).
- Atomic requests occupy two consecutive entries.
- One instance per source in the CCX arbiter.

Parameters:
- DEPTH, 2: queue entries. Legal range is 2..8.
- CNT_W, 2: occupancy counter width. Must satisfy 2**CNT_W > DEPTH.

Ports:
- rclk  in  1  clock.
- reset_d1  in  1  reset, active-high, asynchronous.
- req_q  in  1  new request from source (q stage).
- atom_q  in  1  request is atomic; two packets.
- grant_a  in  1  arbiter granted head entry this cycle.
- qfull  out  1  queue will be full next cycle (combinational from cnt_next).
- wsel  out  DEPTH  one-hot datapath write select (a stage).
- shift_x  out  1  registered shift strobe; datapath shifts entries down by one.
- q0_hold_a  out  1  entry 0 loads this cycle (wsel[0] | shift_x).
- atom_a  out  1  registered atom_q.
- qcnt  out  CNT_W  current occupancy.
- atom_pend  out  1  second half of atomic pending.
- err  out  1  sticky protocol error (see Optional Feature).

Behaviour:
- **Reset (async, reset_d1=1).** All flops clear: req_a, atom_a, qfull_a, cnt, atom_pend, shift_x, err. Outputs at reset: qfull=0, wsel=0, shift_x=0, q0_hold_a=0, atom_a=0, qcnt=0, atom_pend=0, err=0.
- **Stage flops.** req_a<=req_q, atom_a<=atom_q, qfull_a<=qfull. Latency from req_q to write select is 1 cycle.
- **Increment.** incr_a = (req_a | atom_pend) & ~qfull_a. While reset_d1 is asserted, incr_a and decr_a are 0.
- **Decrement.** decr_a = grant_a & (cnt != 0).
- **Next count.** cnt_next = cnt + incr_a - decr_a, computed at CNT_W width. It never wraps.
- **Full flag.** qfull = (cnt_next == DEPTH). Therefore qfull_a == 1 exactly when cnt == DEPTH.
- **Full blocks writes.** While qfull_a=1 no write occurs, even if grant_a=1 in the same cycle. The slot freed by that grant is usable in the following cycle.
- **Write select.** wsel[cnt - decr_a] = incr_a; all other bits are 0. A simultaneous grant and write lands one slot lower.
- **Shift.** shift_a = grant_a & (cnt >= 2); shift_x <= shift_a. Entry 0 reloads from entry 1 in the x cycle.
- **Hold.** q0_hold_a = wsel[0] | shift_x.
- **Atomic set.** atom_pend is set when req_a & atom_a & incr_a. The second packet is written the next cycle through incr_a.
- **Atomic hold.** atom_pend holds while qfull_a=1 and clears once its incr_a fires.
- **Atomic, clearing term.** atom_pend_next = (req_a & atom_a & incr_a) | (atom_pend & ~incr_a).
- **Atomic first half blocked.** An atomic whose first half is blocked by qfull_a is dropped, like any blocked request. The source is credit-limited and must not issue while full.
- **req_a while atom_pend.** Only one entry is written (the atomic second half). The protocol error is flagged.
- **req_a while qfull_a=1.** Request is dropped and the protocol error is flagged.
- **Grant while empty.** grant_a with cnt==0 leaves cnt unchanged, gives shift_a=0, and flags the error.
- **Reset mid-operation.** Reset clears any pending atomic and the count immediately. The datapath contents become don't-care.

Optional Feature:
- Macro: CCX_ARB_SRCQ_ERR_EN.
- **Defined.** err is a sticky flop, set by any of three conditions: req_a & qfull_a; req_a & atom_pend; grant_a & (cnt==0). It is cleared only by reset_d1.
- **Undefined.** err is tied to 0 and no error logic is built. Functional behaviour is otherwise identical.

Test Plan:
- **Back-to-back fill, DEPTH=2.** Pulse req_q 2 cycles, no grant -> wsel=01 then 10; qcnt 1 then 2; qfull high in the 2nd a cycle; qfull_a=1 the next cycle.
- **Grant with shift, DEPTH=4.** Fill to qcnt=3, then grant_a=1 with req_a=1 -> wsel=0100, qcnt stays 3, shift_x=1 one cycle later, q0_hold_a=1 that cycle.
- **Atomic while at DEPTH-1.** req+atom with qcnt=DEPTH-1 -> first half written, qfull_a=1, atom_pend held. Grant -> second half written in the cycle after qfull_a drops; atom_pend clears; final qcnt=DEPTH.
- **Full blocking.** qcnt=DEPTH, grant_a=1 and req_a=1 same cycle -> no write, qcnt=DEPTH-1. With CCX_ARB_SRCQ_ERR_EN, err=1.
- **Empty grant.** grant_a with qcnt=0 -> qcnt stays 0, shift_x=0. err=1 with the macro, 0 without.
- **Async reset.** Assert reset_d1 mid-cycle with qcnt=3 and atom_pend=1 -> all outputs 0 immediately without a clock edge. First req after release writes wsel[0].
